// File: rtl/csr_router_pkg.sv
// csr_router shared types and defaults.
// State enum, default opcodes, error word, index width helper.
package csr_router_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    RRESP = 2'd2
  } state_e;

  localparam logic [3:0] WRITE_COMMAND_DEF = 4'h1;
  localparam logic [3:0] READ_COMMAND_DEF  = 4'h2;
  localparam logic [15:0] ERR_WORD_DEF     = 16'hDEAD;

  // Wide enough to hold NUM_CH itself, which is the
  // counter slot when the error counter is built.
  function automatic int ch_idx_w(input int num_ch);
    return $clog2(num_ch + 1);
  endfunction

endpackage

// File: rtl/csr_router_if.sv
// csr_router word stream interface.
// in_*: host words to router; out_*: read responses back.
interface csr_router_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/csr_router_bank.sv
// csr_bank: NUM_CH x DATA_W register file for csr_router.
// Ports: we/widx/wdata write, ridx/rdata comb read, ch_q, ch_wr.
module csr_bank
  import csr_router_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 4,
  parameter int IW     = ch_idx_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [IW-1:0]            widx,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [IW-1:0]            ridx,
  output logic [DATA_W-1:0]        rdata,
  output logic [NUM_CH*DATA_W-1:0] ch_q,
  output logic [NUM_CH-1:0]        ch_wr
);

  logic [NUM_CH*DATA_W-1:0] regs_q, regs_d;
  logic [NUM_CH-1:0]        wr_q, wr_d;

  always_comb begin
    regs_d = regs_q;
    wr_d   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (we && widx == IW'(i)) begin
        regs_d[i*DATA_W +: DATA_W] = wdata;
        wr_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
      wr_q   <= '0;
    end else begin
      regs_q <= regs_d;
      wr_q   <= wr_d;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ridx == IW'(i)) begin
        rdata = regs_q[i*DATA_W +: DATA_W];
      end
    end
  end

  assign ch_q  = regs_q;
  assign ch_wr = wr_q;

endmodule

// File: rtl/csr_router.sv
// csr_router: decodes {CMD,ADDR} word stream into channel CSR
// writes/reads. Ports: clk, rst_n, bus (slave), ch_q, ch_wr.
// Option CSR_ROUTER_ERR_CNT_EN: 8-bit error counter at
// BASE_ADDR+NUM_CH (read = count, write = clear).
module csr_router
  import csr_router_pkg::*;
#(
  parameter int                DATA_W        = 16,
  parameter int                CMD_W         = 4,
  parameter int                ADDR_W        = 12,
  parameter int                NUM_CH        = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = '0,
  parameter logic [CMD_W-1:0]  WRITE_COMMAND = WRITE_COMMAND_DEF,
  parameter logic [CMD_W-1:0]  READ_COMMAND  = READ_COMMAND_DEF,
  parameter logic [DATA_W-1:0] ERR_WORD      = ERR_WORD_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  csr_router_if.slave              bus,
  output logic [NUM_CH*DATA_W-1:0] ch_q,
  output logic [NUM_CH-1:0]        ch_wr
);

  localparam int IW = ch_idx_w(NUM_CH);

  state_e            state_q, state_d;
  logic [IW-1:0]     widx_q, widx_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic [CMD_W-1:0]  cmd;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] idx;
  logic              in_rng;
  logic              wr_ok;
  logic              in_fire;
  logic              is_wr;
  logic              is_rd;
  logic              bank_we;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] miss_word;

  assign cmd    = bus.in_data[DATA_W-1 -: CMD_W];
  assign addr   = bus.in_data[ADDR_W-1:0];
  assign idx    = addr - BASE_ADDR;
  assign in_rng = idx < ADDR_W'(NUM_CH);
  assign is_wr  = cmd == WRITE_COMMAND;
  assign is_rd  = cmd == READ_COMMAND;

  assign bus.in_ready  = state_q != RRESP;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign in_fire = bus.in_valid && bus.in_ready;

`ifdef CSR_ROUTER_ERR_CNT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       cnt_hit;
  logic       err_evt;
  logic       cnt_clr;

  assign cnt_hit   = idx == ADDR_W'(NUM_CH);
  assign wr_ok     = in_rng || cnt_hit;
  assign miss_word = cnt_hit ? {{(DATA_W-8){1'b0}}, cnt_q}
                             : ERR_WORD;
  assign err_evt = in_fire && state_q == IDLE &&
                   (is_wr ? !wr_ok : !is_rd);
  // A data word aimed at the counter slot clears it.
  assign cnt_clr = in_fire && state_q == WDATA &&
                   widx_q == IW'(NUM_CH);

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (err_evt && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign wr_ok     = in_rng;
  assign miss_word = ERR_WORD;
`endif

  always_comb begin
    state_d     = state_q;
    widx_d      = widx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    bank_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          unique case (1'b1)
            is_wr: begin
              if (wr_ok) begin
                widx_d  = idx[IW-1:0];
                state_d = WDATA;
              end
            end
            is_rd: begin
              out_data_d  = in_rng ? rdata : miss_word;
              out_valid_d = 1'b1;
              state_d     = RRESP;
            end
            default: ;
          endcase
        end
      end
      WDATA: begin
        if (in_fire) begin
          bank_we = widx_q < IW'(NUM_CH);
          state_d = IDLE;
        end
      end
      RRESP: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      widx_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      widx_q      <= widx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  csr_bank #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH),
    .IW     (IW)
  ) u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bank_we),
    .widx  (widx_q),
    .wdata (bus.in_data),
    .ridx  (idx[IW-1:0]),
    .rdata (rdata),
    .ch_q  (ch_q),
    .ch_wr (ch_wr)
  );

endmodule

// File: tb/tb_csr_router.sv
// tb_csr_router: directed + random words against a
// behavioural channel/counter model.
module tb_csr_router;

`ifdef CSR_ROUTER_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [63:0] ch_q;
  logic [3:0]  ch_wr;

  csr_router_if #(.DATA_W(16)) bus ();

  csr_router dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .ch_q  (ch_q),
    .ch_wr (ch_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  logic [15:0] m_ch [4];
  int          m_err;
  int          pend;
  logic [15:0] last_out;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_ch[i] = '0;
    m_err = 0;
    pend  = -1;
  endtask

  function automatic logic [63:0] m_pack();
    logic [63:0] p;
    for (int i = 0; i < 4; i++) p[i*16 +: 16] = m_ch[i];
    return p;
  endfunction

  // Apply one accepted word to the model.
  task automatic m_word(input  logic [15:0] w,
                        output logic [3:0]  wr,
                        output bit          rd,
                        output logic [15:0] rsp);
    int c;
    int a;
    wr  = '0;
    rd  = 1'b0;
    rsp = '0;
    c   = int'(w[15:12]);
    a   = int'(w[11:0]);
    if (pend >= 0) begin
      if (pend < 4) begin
        m_ch[pend] = w;
        wr = 4'(1 << pend);
      end else begin
        m_err = 0;
      end
      pend = -1;
    end else if (c == 1) begin
      if (a < 4 || (CNT_EN && a == 4)) pend = a;
      else if (m_err < 255) m_err++;
    end else if (c == 2) begin
      rd = 1'b1;
      if (a < 4) rsp = m_ch[a];
      else if (CNT_EN && a == 4) rsp = 16'(m_err);
      else rsp = 16'hDEAD;
    end else if (m_err < 255) begin
      m_err++;
    end
  endtask

  task automatic do_word(input logic [15:0] w,
                         input int bp,
                         input bit early);
    bit          ok;
    logic [3:0]  e_wr;
    bit          e_rd;
    logic [15:0] e_rsp;
    bus.out_ready = early;
    @(negedge clk);
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("in_ready_wait", 64'(ok), 64'd1);
    if (!ok) begin
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    m_word(w, e_wr, e_rd, e_rsp);
    chk("ch_wr", 64'(ch_wr), 64'(e_wr));
    chk("ch_q", ch_q, m_pack());
    if (e_rd) begin
      last_out = bus.out_data;
      chk("rd_valid", 64'(bus.out_valid), 64'd1);
      chk("rd_data", 64'(bus.out_data), 64'(e_rsp));
      chk("rd_in_ready", 64'(bus.in_ready), 64'd0);
      if (!early) begin
        repeat (bp) begin
          @(posedge clk);
          #1;
          chk("bp_valid", 64'(bus.out_valid), 64'd1);
          chk("bp_data", 64'(bus.out_data), 64'(e_rsp));
          chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("done_valid", 64'(bus.out_valid), 64'd0);
      chk("done_in_ready", 64'(bus.in_ready), 64'd1);
      chk("done_ch_wr", 64'(ch_wr), 64'd0);
    end else begin
      chk("no_valid", 64'(bus.out_valid), 64'd0);
      chk("in_ready", 64'(bus.in_ready), 64'd1);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset(input bit now);
    if (!now) @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("rst_ch_wr", 64'(ch_wr), 64'd0);
    chk("rst_ch_q", ch_q, 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] rnd_word();
    logic [3:0]  c;
    logic [11:0] a;
    int          s;
    s = int'($urandom_range(0, 9));
    if (s < 4) c = 4'h1;
    else if (s < 7) c = 4'h2;
    else c = 4'($urandom);
    if ($urandom_range(0, 7) == 0) a = 12'($urandom);
    else a = 12'($urandom_range(0, 6));
    return {c, a};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    last_out = '0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("por_ch_q", ch_q, 64'd0);
    chk("por_ch_wr", 64'(ch_wr), 64'd0);
    chk("por_valid", 64'(bus.out_valid), 64'd0);
    chk("por_data", 64'(bus.out_data), 64'd0);
    chk("por_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Write channel 1.
    do_word(16'h1001, 0, 1'b0);
    do_word(16'hA5A5, 0, 1'b0);
    chk("plan_wr_ch1", 64'(ch_q[31:16]), 64'hA5A5);
    chk("plan_wr_pulse", 64'(ch_wr), 64'b0010);

    // Read with backpressure.
    do_word(16'h2001, 5, 1'b0);
    chk("plan_rd_bp", 64'(last_out), 64'hA5A5);

    // Out of range read and write.
    do_word(16'h2009, 2, 1'b0);
    chk("plan_oor_rd", 64'(last_out), 64'hDEAD);
    do_word(16'h1009, 0, 1'b0);
    do_word(16'h1234, 0, 1'b0);

    // Data word that looks like a read command.
    do_word(16'h1000, 0, 1'b0);
    do_word(16'h2001, 0, 1'b1);
    chk("plan_mimic", 64'(ch_q[15:0]), 64'h2001);

    // Read-after-write, out_ready high early.
    do_word(16'h1003, 0, 1'b1);
    do_word(16'h7E57, 0, 1'b1);
    do_word(16'h2003, 0, 1'b1);
    chk("plan_raw", 64'(last_out), 64'h7E57);

    // Reset between command and data word.
    do_word(16'h1002, 0, 1'b0);
    do_reset(1'b0);
    do_word(16'h5555, 0, 1'b0);
    chk("plan_rst_q", ch_q, 64'd0);

    // Reset lands while a ch_wr pulse is high.
    do_word(16'h1000, 0, 1'b0);
    do_word(16'h4321, 0, 1'b0);
    do_reset(1'b1);

    // Error counter read and clear.
    repeat (3) do_word(16'hF000, 0, 1'b0);
    do_word(16'h2004, 1, 1'b0);
    if (CNT_EN) chk("plan_cnt", 64'(last_out), 64'h0003);
    else chk("plan_cnt_off", 64'(last_out), 64'hDEAD);
    do_word(16'h1004, 0, 1'b0);
    do_word(16'h0000, 0, 1'b0);
    do_word(16'h2004, 0, 1'b0);

    // Saturation.
    repeat (260) do_word(16'hF123, 0, 1'b1);
    do_word(16'h2004, 0, 1'b0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      if (i % 60 == 59) do_reset(1'b0);
      do_word(rnd_word(), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
